// File: rtl/nibble_link_ctrl.sv
// nibble_link_ctrl
//   Receives 4-bit nibbles over a 4-phase req/ack port and pairs them into bytes.
//   The first nibble of a pair becomes bits [3:0] and the second becomes bits [7:4].
//   Completed bytes are queued in a DEPTH-entry FIFO. The head of the FIFO is shown
//   to the CPU load path as the zero-extended word {24'h0, byte}.
//   A watchdog discards a low nibble if its high nibble never arrives.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   nib_in       nibble data, valid while nib_stb is high
//   nib_stb      source request (level, 4-phase)
//   nib_ack      acknowledge (level, 4-phase), registered
//   rd_en        pop the head entry (ignored when empty)
//   rd_data      {24'h0, head byte}, 32'h0 when empty
//   rd_valid     FIFO non-empty
//   full         committed bytes == DEPTH
//   level        committed byte count
//   err_timeout  sticky flag: a low nibble was dropped by the watchdog
//   err_clr      clears err_timeout (a timeout in the same cycle wins)
//
// State table
//   WAIT_LO | idle, waiting for the low-nibble request
//   ACK_LO  | low nibble latched, ack high, waiting for req to drop
//   WAIT_HI | waiting for the high-nibble request, watchdog running
//   ACK_HI  | byte pushed, ack high, waiting for req to drop
module nibble_link_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               nib_in,
    input  logic                     nib_stb,
    output logic                     nib_ack,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_timeout,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_LO = 2'd0,
        ACK_LO  = 2'd1,
        WAIT_HI = 2'd2,
        ACK_HI  = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      lo_nib;
    logic [WW-1:0]   wdog;
    logic            reserved;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;

    logic            push;
    logic            pop;
    logic            wdog_expired;
    logic [LW:0]     occupied;
    logic            slot_free;

    assign push         = (state == WAIT_HI) && nib_stb;
    assign pop          = rd_en && (count != '0);
    assign wdog_expired = (state == WAIT_HI) && !nib_stb && (wdog == WW'(TIMEOUT - 1));

    // A byte in flight keeps its slot from the low nibble onward. This means the
    // high-nibble push can never land on a full FIFO.
    assign occupied  = {1'b0, count} + {{LW{1'b0}}, reserved};
    assign slot_free = occupied < (LW + 1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LO;
            nib_ack     <= 1'b0;
            lo_nib      <= 4'h0;
            wdog        <= '0;
            reserved    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (wdog_expired) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (state)
                WAIT_LO: begin
                    if (nib_stb && slot_free) begin
                        lo_nib   <= nib_in;
                        reserved <= 1'b1;
                        nib_ack  <= 1'b1;
                        state    <= ACK_LO;
                    end
                end
                ACK_LO: begin
                    if (!nib_stb) begin
                        nib_ack <= 1'b0;
                        wdog    <= '0;
                        state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A request arriving in the expiry cycle still completes the byte.
                    if (nib_stb) begin
                        reserved <= 1'b0;
                        nib_ack  <= 1'b1;
                        state    <= ACK_HI;
                    end else if (wdog_expired) begin
                        reserved <= 1'b0;
                        state    <= WAIT_LO;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ACK_HI: begin
                    if (!nib_stb) begin
                        nib_ack <= 1'b0;
                        state   <= WAIT_LO;
                    end
                end
                default: begin
                    nib_ack <= 1'b0;
                    state   <= WAIT_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {nib_in, lo_nib};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_valid = (count != '0);
    assign full     = (count == LW'(DEPTH));
    assign level    = count;
    assign rd_data  = rd_valid ? {24'h0, mem[rd_ptr]} : 32'h0;

endmodule

// File: tb/tb_nibble_link_ctrl.sv
module tb_nibble_link_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  nib_in;
    logic        nib_stb;
    logic        nib_ack;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic [2:0]  level;
    logic        err_timeout;
    logic        err_clr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];

    nibble_link_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nib_in      (nib_in),
        .nib_stb     (nib_stb),
        .nib_ack     (nib_ack),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .level       (level),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop is compared with the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && rd_en) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %h expected no entry", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", rd_data, {24'h0, e});
                end
            end else begin
                check("empty_rd_data", rd_data, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nib_ack === v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in  = n;
        nib_stb = 1'b1;
        wait_ack(1'b1, "ack_rise");
        nib_stb = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!rd_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        rd_en = 1'b0;
        check("drain_done", 32'(ok), 32'd1);
    endtask

    initial begin
        bit acked;
        nib_in  = 4'h0;
        nib_stb = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", 32'(nib_ack), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_err", 32'(err_timeout), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single byte A then 5.
        send_byte(8'h5A);
        check("byte_valid", 32'(rd_valid), 32'd1);
        check("byte_rd_data", rd_data, 32'h0000_005A);
        check("byte_level", 32'(level), 32'd1);
        pop_one();
        check("byte_pop_valid", 32'(rd_valid), 32'd0);
        check("byte_pop_rd_data", rd_data, 32'h0);

        // Fill, stall the fifth byte, release it with one pop.
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_level", 32'(level), 32'd4);
        nib_in  = 4'h5;
        nib_stb = 1'b1;
        acked   = 1'b0;
        repeat (5) begin
            tick();
            if (nib_ack) acked = 1'b1;
        end
        check("full_stall_ack", 32'(acked), 32'd0);
        pop_one();
        check("ack_gated_at_pop", 32'(nib_ack), 32'd0);
        tick();
        check("ack_after_pop", 32'(nib_ack), 32'd1);
        nib_stb = 1'b0;
        wait_ack(1'b0, "ack_fall");
        exp_q.push_back(8'h05);
        send_nib(4'h0);
        check("refill_full", 32'(full), 32'd1);
        drain();
        check("drained_level", 32'(level), 32'd0);

        // Watchdog: low nibble 3 abandoned.
        nib_in  = 4'h3;
        nib_stb = 1'b1;
        wait_ack(1'b1, "ack_rise");
        nib_stb = 1'b0;
        repeat (TIMEOUT) tick();
        check("no_early_timeout", 32'(err_timeout), 32'd0);
        tick();
        check("timeout_set", 32'(err_timeout), 32'd1);
        check("timeout_level", 32'(level), 32'd0);
        check("timeout_ack", 32'(nib_ack), 32'd0);
        send_byte(8'h21);
        check("after_timeout_data", rd_data, 32'h0000_0021);
        check("err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err_timeout), 32'd0);
        // The dropped byte must have given back its slot.
        for (int i = 2; i <= 4; i++) send_byte(8'h20 + 8'(i));
        check("timeout_slot_released", 32'(full), 32'd1);
        drain();

        // Push and pop in the same cycle.
        send_byte(8'h41);
        send_byte(8'h42);
        check("sim_level_before", 32'(level), 32'd2);
        exp_q.push_back(8'h43);
        send_nib(4'h3);
        nib_in  = 4'h4;
        nib_stb = 1'b1;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        check("sim_level_after", 32'(level), 32'd2);
        wait_ack(1'b1, "ack_rise");
        nib_stb = 1'b0;
        wait_ack(1'b0, "ack_fall");
        drain();
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check("empty_rd_level", 32'(level), 32'd0);
        check("empty_rd_valid", 32'(rd_valid), 32'd0);

        // Stream ten bytes through, keeping the FIFO partly occupied so pointers wrap.
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h80 + 8'(i));
            if (i >= 2) pop_one();
        end
        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid ACK_HI.
        send_nib(4'h7);
        nib_in  = 4'h9;
        nib_stb = 1'b1;
        wait_ack(1'b1, "ack_rise");
        check("pre_rst_level", 32'(level), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(nib_ack), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_rd_data", rd_data, 32'h0);
        check("midrst_valid", 32'(rd_valid), 32'd0);
        nib_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        send_byte(8'hC3);
        check("post_rst_data", rd_data, 32'h0000_00C3);
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1, "bench time limit reached");
    end

endmodule
